// File: rtl/bist_word_sequencer.sv
// Streams a fixed table of test words into the BIST accumulator over valid/ready.
// It also tracks the sum and carry that the accumulator is expected to produce.
module bist_word_sequencer #(
  parameter int WIDTH = 3,
  parameter int NUM_WORDS = 4,
  parameter logic [WIDTH*NUM_WORDS-1:0] PATTERN = 12'b100_011_111_010,
  parameter int PASSES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             word_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             acc_clear,
  output logic [WIDTH-1:0] exp_sum,
  output logic             exp_carry,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int PASS_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  state_t            state_reg;
  logic [IDX_W-1:0]  index_reg;
  logic [IDX_W-1:0]  index_next;
  logic [PASS_W-1:0] pass_reg;
  logic [WIDTH:0]    sum_next;
  logic              last_word;
  logic              last_pass;
  logic [WIDTH-1:0]  words [NUM_WORDS];

  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
      assign words[gi] = PATTERN[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign index_next = index_reg + IDX_W'(1);
  assign last_word  = (index_reg == IDX_W'(NUM_WORDS - 1));
  assign last_pass  = (pass_reg == PASS_W'(PASSES - 1));
  assign sum_next   = {1'b0, exp_sum} + {1'b0, word_out};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      index_reg  <= '0;
      pass_reg   <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      acc_clear  <= 1'b0;
      exp_sum    <= '0;
      exp_carry  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      acc_clear <= 1'b0;
      done      <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // start beats abort here; abort is meaningless while idle
          if (start) begin
            state_reg <= S_CLEAR;
            acc_clear <= 1'b1;
            busy      <= 1'b1;
            exp_sum   <= '0;
            exp_carry <= 1'b0;
            index_reg <= '0;
            pass_reg  <= '0;
          end
        end
        S_CLEAR: begin
          if (abort) begin
            state_reg <= S_IDLE;
            busy      <= 1'b0;
          end else begin
            state_reg  <= S_RUN;
            word_valid <= 1'b1;
            word_out   <= words[0];
          end
        end
        S_RUN: begin
          // An abort discards any transfer offered in the same cycle
          if (abort) begin
            state_reg  <= S_IDLE;
            word_valid <= 1'b0;
            word_out   <= '0;
            busy       <= 1'b0;
          end else if (word_ready) begin
            {exp_carry, exp_sum} <= sum_next;
            if (last_word) begin
              index_reg <= '0;
              if (last_pass) begin
                state_reg  <= S_DONE;
                word_valid <= 1'b0;
                word_out   <= '0;
                done       <= 1'b1;
              end else begin
                pass_reg <= pass_reg + PASS_W'(1);
                word_out <= words[0];
              end
            end else begin
              index_reg <= index_next;
              word_out  <= words[index_next];
            end
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_word_sequencer.sv
// Self-checking bench for bist_word_sequencer: a one-pass and a two-pass instance share stimulus.
// Expected words and sums come from a transfer-count model of the test table.
module tb_bist_word_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, abort, word_ready;
  logic [2:0] word_out_d [2];
  logic       word_valid_d [2];
  logic       acc_clear_d [2];
  logic [2:0] exp_sum_d [2];
  logic       exp_carry_d [2];
  logic       busy_d [2];
  logic       done_d [2];

  logic [2:0] pat [4] = '{3'b010, 3'b111, 3'b011, 3'b100};
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bist_word_sequencer #(.PASSES(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .word_ready(word_ready),
    .word_out(word_out_d[0]), .word_valid(word_valid_d[0]), .acc_clear(acc_clear_d[0]),
    .exp_sum(exp_sum_d[0]), .exp_carry(exp_carry_d[0]), .busy(busy_d[0]), .done(done_d[0])
  );

  bist_word_sequencer #(.PASSES(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .word_ready(word_ready),
    .word_out(word_out_d[1]), .word_valid(word_valid_d[1]), .acc_clear(acc_clear_d[1]),
    .exp_sum(exp_sum_d[1]), .exp_carry(exp_carry_d[1]), .busy(busy_d[1]), .done(done_d[1])
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; word_ready = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; word_ready = 1'b0;
    cycle();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({word_out_d[d], word_valid_d[d], acc_clear_d[d], exp_sum_d[d], exp_carry_d[d],
           busy_d[d], done_d[d]} !== 11'b0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got %b %b %b %b %b %b %b, expected all zero", d,
                 word_out_d[d], word_valid_d[d], acc_clear_d[d], exp_sum_d[d], exp_carry_d[d],
                 busy_d[d], done_d[d]);
      end
    end
    reset = 1'b0;
    cycle();
    n_checks++;
    if (busy_d[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start: busy=%b expected 0", busy_d[0]);
    end
  endtask

  task automatic test_basic();
    logic [3:0] tot;
    logic [2:0] s;
    logic       c;
    do_reset();
    s = 3'b000; c = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    n_checks++;
    if (acc_clear_d[0] !== 1'b1 || word_valid_d[0] !== 1'b0 || busy_d[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_clear: acc_clear=%b valid=%b busy=%b, expected 1 0 1",
               acc_clear_d[0], word_valid_d[0], busy_d[0]);
    end
    word_ready = 1'b1;
    cycle();
    n_checks++;
    if (acc_clear_d[0] !== 1'b0 || exp_sum_d[0] !== 3'b000 || exp_carry_d[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_first_run: acc_clear=%b sum=%b carry=%b, expected 0 000 0",
               acc_clear_d[0], exp_sum_d[0], exp_carry_d[0]);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (word_valid_d[0] !== 1'b1 || word_out_d[0] !== pat[k]) begin
        n_fail++;
        $display("FAIL basic_word k=%0d: valid=%b word=%b, expected 1 %b", k,
                 word_valid_d[0], word_out_d[0], pat[k]);
      end
      cycle();
      tot = {1'b0, s} + {1'b0, pat[k]};
      c = tot[3]; s = tot[2:0];
      n_checks++;
      if ({exp_carry_d[0], exp_sum_d[0]} !== {c, s} || done_d[0] !== (k == 3)) begin
        n_fail++;
        $display("FAIL basic_sum k=%0d: carry_sum=%b done=%b, expected %b %b", k,
                 {exp_carry_d[0], exp_sum_d[0]}, done_d[0], {c, s}, (k == 3));
      end
    end
    cycle();
    n_checks++;
    if (done_d[0] !== 1'b0 || busy_d[0] !== 1'b0 || {exp_carry_d[0], exp_sum_d[0]} !== 4'b1000) begin
      n_fail++;
      $display("FAIL basic_after_done: done=%b busy=%b carry_sum=%b, expected 0 0 1000",
               done_d[0], busy_d[0], {exp_carry_d[0], exp_sum_d[0]});
    end
  endtask

  task automatic test_stall();
    logic [3:0] tot;
    logic [2:0] s;
    do_reset();
    start = 1'b1; cycle(); start = 1'b0;
    word_ready = 1'b1;
    cycle(); cycle();
    word_ready = 1'b0;
    s = pat[0];
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (word_valid_d[0] !== 1'b1 || word_out_d[0] !== 3'b111 || exp_sum_d[0] !== 3'b010) begin
        n_fail++;
        $display("FAIL stall_hold i=%0d: valid=%b word=%b sum=%b, expected 1 111 010", i,
                 word_valid_d[0], word_out_d[0], exp_sum_d[0]);
      end
    end
    word_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      n_checks++;
      if (word_out_d[0] !== pat[k]) begin
        n_fail++;
        $display("FAIL stall_word k=%0d: word=%b expected %b", k, word_out_d[0], pat[k]);
      end
      cycle();
      tot = {1'b0, s} + {1'b0, pat[k]};
      s = tot[2:0];
      n_checks++;
      if ({exp_carry_d[0], exp_sum_d[0]} !== tot || done_d[0] !== (k == 3)) begin
        n_fail++;
        $display("FAIL stall_sum k=%0d: carry_sum=%b done=%b, expected %b %b", k,
                 {exp_carry_d[0], exp_sum_d[0]}, done_d[0], tot, (k == 3));
      end
    end
  endtask

  task automatic test_two_passes();
    int n_done, n_xfer;
    do_reset();
    start = 1'b1; cycle(); start = 1'b0;
    word_ready = 1'b1;
    n_done = 0; n_xfer = 0;
    for (int i = 0; i < 14; i++) begin
      if (word_valid_d[1] && word_ready) n_xfer++;
      cycle();
      if (done_d[1]) n_done++;
    end
    n_checks++;
    if (n_xfer != 8 || n_done != 1) begin
      n_fail++;
      $display("FAIL two_pass_count: transfers=%0d dones=%0d, expected 8 1", n_xfer, n_done);
    end
    n_checks++;
    if ({exp_carry_d[1], exp_sum_d[1], busy_d[1]} !== 5'b1_000_0) begin
      n_fail++;
      $display("FAIL two_pass_final: carry=%b sum=%b busy=%b, expected 1 000 0",
               exp_carry_d[1], exp_sum_d[1], busy_d[1]);
    end
  endtask

  task automatic test_abort();
    do_reset();
    start = 1'b1; cycle(); start = 1'b0;
    word_ready = 1'b1;
    cycle(); cycle(); cycle();
    abort = 1'b1; cycle(); abort = 1'b0;
    n_checks++;
    if (busy_d[0] !== 1'b0 || word_valid_d[0] !== 1'b0 || exp_sum_d[0] !== 3'b001 ||
        exp_carry_d[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_run: busy=%b valid=%b sum=%b carry=%b, expected 0 0 001 1",
               busy_d[0], word_valid_d[0], exp_sum_d[0], exp_carry_d[0]);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (done_d[0] !== 1'b0 || exp_sum_d[0] !== 3'b001) begin
        n_fail++;
        $display("FAIL abort_no_done i=%0d: done=%b sum=%b, expected 0 001", i,
                 done_d[0], exp_sum_d[0]);
      end
    end
    start = 1'b1; cycle(); start = 1'b0;
    cycle();
    n_checks++;
    if (exp_sum_d[0] !== 3'b000 || exp_carry_d[0] !== 1'b0 || word_out_d[0] !== pat[0]) begin
      n_fail++;
      $display("FAIL abort_restart: sum=%b carry=%b word=%b, expected 000 0 %b",
               exp_sum_d[0], exp_carry_d[0], word_out_d[0], pat[0]);
    end
    do_reset();
    start = 1'b1; abort = 1'b1; cycle(); start = 1'b0;
    n_checks++;
    if (acc_clear_d[0] !== 1'b1 || busy_d[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL start_abort_idle: acc_clear=%b busy=%b, expected 1 1",
               acc_clear_d[0], busy_d[0]);
    end
    cycle(); abort = 1'b0;
    n_checks++;
    if (busy_d[0] !== 1'b0 || word_valid_d[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_clear: busy=%b valid=%b, expected 0 0", busy_d[0], word_valid_d[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start = 1'b1; cycle(); start = 1'b0;
    word_ready = 1'b1;
    cycle(); cycle();
    word_ready = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (acc_clear_d[0] !== 1'b0 || word_out_d[0] !== 3'b111 || busy_d[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL start_while_busy i=%0d: acc_clear=%b word=%b busy=%b, expected 0 111 1",
                 i, acc_clear_d[0], word_out_d[0], busy_d[0]);
      end
    end
    start = 1'b0; reset = 1'b1;
    cycle();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({word_out_d[d], word_valid_d[d], acc_clear_d[d], exp_sum_d[d], exp_carry_d[d],
           busy_d[d], done_d[d]} !== 11'b0) begin
        n_fail++;
        $display("FAIL reset_mid dut%0d: got %b %b %b %b %b %b %b, expected all zero", d,
                 word_out_d[d], word_valid_d[d], acc_clear_d[d], exp_sum_d[d], exp_carry_d[d],
                 busy_d[d], done_d[d]);
      end
    end
    reset = 1'b0;
    cycle();
    n_checks++;
    if (busy_d[0] !== 1'b0 || acc_clear_d[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_after: busy=%b acc_clear=%b, expected 0 0", busy_d[0], acc_clear_d[0]);
    end
  endtask

  task automatic test_random();
    int         sent [2];
    int         total [2];
    int         phase [2];   // 0 streaming, 1 done cycle, 2 idle
    logic [2:0] msum [2];
    logic       mcarry [2];
    logic       exp_v [2];
    logic       xfer [2];
    logic [3:0] tot;
    total[0] = 4; total[1] = 8;
    for (int run = 0; run < 4; run++) begin
      do_reset();
      for (int d = 0; d < 2; d++) begin
        sent[d] = 0; phase[d] = 0; msum[d] = 3'b000; mcarry[d] = 1'b0;
      end
      start = 1'b1; cycle(); start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (acc_clear_d[d] !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_clear run=%0d dut%0d: acc_clear=%b expected 1", run, d, acc_clear_d[d]);
        end
      end
      cycle();
      for (int cyc = 0; cyc < 200 && !(phase[0] == 2 && phase[1] == 2); cyc++) begin
        word_ready = 1'($urandom_range(0, 1));
        for (int d = 0; d < 2; d++) begin
          exp_v[d] = (phase[d] == 0);
          xfer[d]  = exp_v[d] && word_ready;
          n_checks++;
          if (word_valid_d[d] !== exp_v[d] || (exp_v[d] && word_out_d[d] !== pat[sent[d] % 4])) begin
            n_fail++;
            $display("FAIL rand_word run=%0d dut%0d cyc=%0d: valid=%b word=%b, expected %b %b",
                     run, d, cyc, word_valid_d[d], word_out_d[d], exp_v[d], pat[sent[d] % 4]);
          end
        end
        cycle();
        for (int d = 0; d < 2; d++) begin
          if (phase[d] == 1) phase[d] = 2;
          if (xfer[d]) begin
            tot = {1'b0, msum[d]} + {1'b0, pat[sent[d] % 4]};
            mcarry[d] = tot[3]; msum[d] = tot[2:0];
            sent[d]++;
            if (sent[d] == total[d]) phase[d] = 1;
          end
          n_checks++;
          if ({exp_carry_d[d], exp_sum_d[d]} !== {mcarry[d], msum[d]} ||
              done_d[d] !== (phase[d] == 1) || busy_d[d] !== (phase[d] != 2)) begin
            n_fail++;
            $display("FAIL rand_state run=%0d dut%0d cyc=%0d: carry_sum=%b done=%b busy=%b, expected %b %b %b",
                     run, d, cyc, {exp_carry_d[d], exp_sum_d[d]}, done_d[d], busy_d[d],
                     {mcarry[d], msum[d]}, (phase[d] == 1), (phase[d] != 2));
          end
        end
      end
      n_checks++;
      if (!(phase[0] == 2 && phase[1] == 2)) begin
        n_fail++;
        $display("FAIL rand_timeout run=%0d: phases %0d %0d, expected 2 2", run, phase[0], phase[1]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; word_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_two_passes();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
